// File: rtl/pmem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : pmem_arbiter_pkg
// Brief  : Shared types for the I/D-cache to physical-memory arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pmem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_client_t;

endpackage

`default_nettype wire

// File: rtl/pmem_arbiter.sv
//------------------------------------------------------------------------------
// Module : pmem_arbiter
// Brief  : Round-robin arbiter of I-cache and D-cache line transfers onto one
//          physical-memory port, one transaction outstanding.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  arb_client_t           r_last_grant;
  arb_client_t           w_grant_client;
  logic                  w_grant;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_busy;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  always_comb begin
    w_state_next   = r_state;
    w_grant        = 1'b0;
    w_grant_client = ARB_I;
    case (r_state)
      IDLE: begin
        // On a tie the client that did not win last time goes first.
        if (w_i_req && w_d_req) begin
          w_grant        = 1'b1;
          w_grant_client = (r_last_grant == ARB_I) ? ARB_D : ARB_I;
        end else if (w_i_req) begin
          w_grant        = 1'b1;
          w_grant_client = ARB_I;
        end else if (w_d_req) begin
          w_grant        = 1'b1;
          w_grant_client = ARB_D;
        end
        if (w_grant) begin
          w_state_next = (w_grant_client == ARB_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I:  if (pmem_resp) w_state_next = RESP_I;
      BUSY_D:  if (pmem_resp) w_state_next = RESP_D;
      RESP_I:  w_state_next = IDLE;
      RESP_D:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ARB_I;
    end else begin
      r_state <= w_state_next;
      if (w_grant) r_last_grant <= w_grant_client;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_write <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant) begin
        if (w_grant_client == ARB_D) begin
          r_address  <= d_address & c_align_mask;
          r_wdata    <= d_wdata;
          r_op_write <= d_write;
        end else begin
          r_address  <= i_address & c_align_mask;
          r_op_write <= 1'b0;
        end
      end
      if (r_state == BUSY_I && pmem_resp) r_i_rdata <= pmem_rdata;
      if (r_state == BUSY_D && pmem_resp && !r_op_write) r_d_rdata <= pmem_rdata;
    end
  end

  // Every output is a decode of registered state only.
  assign w_busy       = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign pmem_read    = w_busy && !r_op_write;
  assign pmem_write   = w_busy && r_op_write;
  assign pmem_address = r_address;
  assign pmem_wdata   = r_wdata;
  assign i_resp       = (r_state == RESP_I);
  assign d_resp       = (r_state == RESP_D);
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;

endmodule

`default_nettype wire
